// File: rtl/dmem_pkg.sv
// Shared types, constants and parity helper for the dmem_responder data memory.
package dmem_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        SERVE = 1'b1
    } state_t;

    localparam int WORD_BYTES = 4;

    // Even parity: the stored bit makes the total count of ones in byte+bit even.
    function automatic logic byte_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised storage: byte-strobed synchronous write, combinational read.
// Optional per-byte parity lane when DMEM_PARITY_EN is defined.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int ADDR_BITS = 12
) (
    input  logic                  clk,
    input  logic [WORD_BYTES-1:0] i_we,
    input  logic [ADDR_BITS-1:0]  i_waddr,
    input  logic [31:0]           i_wdata,
    input  logic [ADDR_BITS-1:0]  i_raddr,
    output logic [31:0]           o_rdata
`ifdef DMEM_PARITY_EN
    ,
    output logic                  o_par_mismatch
`endif
);

    localparam int DEPTH = 1 << ADDR_BITS;

    // No reset on the array: contents are established by the clear sweep.
    logic [31:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int i = 0; i < WORD_BYTES; i++) begin
            if (i_we[i]) begin
                r_mem[i_waddr][8*i +: 8] <= i_wdata[8*i +: 8];
            end
        end
    end

    assign o_rdata = r_mem[i_raddr];

`ifdef DMEM_PARITY_EN
    logic [WORD_BYTES-1:0] r_par [DEPTH];
    logic [WORD_BYTES-1:0] w_rpar;

    always_ff @(posedge clk) begin
        for (int i = 0; i < WORD_BYTES; i++) begin
            if (i_we[i]) begin
                r_par[i_waddr][i] <= byte_parity(i_wdata[8*i +: 8]);
            end
        end
    end

    assign w_rpar = r_par[i_raddr];

    always_comb begin
        o_par_mismatch = 1'b0;
        for (int i = 0; i < WORD_BYTES; i++) begin
            if (w_rpar[i] != byte_parity(o_rdata[8*i +: 8])) begin
                o_par_mismatch = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/dmem_responder.sv
// CPU data-port memory responder: post-reset clear sweep, zero-latency reads,
// byte-strobed writes, sticky range/parity error flags (parity via DMEM_PARITY_EN).
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int          ADDR_BITS  = 12,
    parameter logic [31:0] INIT_VALUE = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_read,
    input  logic [3:0]  data_write,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        ready,
    output logic        addr_err,
    output logic        par_err
);

    localparam logic [ADDR_BITS-1:0] LAST_IDX = '1;

    // r_state is the FSM state exposed for checkers; handshake-free port:
    // an access is qualified purely by data_read / data_write in SERVE.
    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [ADDR_BITS-1:0]   r_clr_cnt;
    logic [ADDR_BITS-1:0]   w_clr_cnt_nxt;
    logic                   r_addr_err;

    logic                   w_serve;
    logic                   w_in_range;
    logic                   w_access;
    logic [ADDR_BITS-1:0]   w_idx;
    logic [WORD_BYTES-1:0]  w_we;
    logic [ADDR_BITS-1:0]   w_waddr;
    logic [31:0]            w_wdata;
    logic [31:0]            w_rdata;
    logic [1:0]             w_unused_addr_lsb;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= CLEAR;
            r_clr_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_cnt <= w_clr_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_clr_cnt_nxt = r_clr_cnt;
        case (r_state)
            CLEAR: begin
                w_clr_cnt_nxt = r_clr_cnt + 1'b1;
                if (r_clr_cnt == LAST_IDX) begin
                    w_state_nxt = SERVE;
                end
            end
            SERVE: begin
                w_state_nxt = SERVE;
            end
            default: begin
                w_state_nxt = CLEAR;
            end
        endcase
    end

    assign w_serve           = (r_state == SERVE);
    assign w_in_range        = (data_addr[31:ADDR_BITS+2] == '0);
    assign w_idx             = data_addr[ADDR_BITS+1:2];
    assign w_access          = data_read || (data_write != 4'b0000);
    assign w_unused_addr_lsb = data_addr[1:0];

    // The sweep owns the write port while in CLEAR; CPU traffic is dropped.
    assign w_we    = !w_serve ? {WORD_BYTES{1'b1}} :
                     (w_in_range ? data_write : {WORD_BYTES{1'b0}});
    assign w_waddr = w_serve ? w_idx : r_clr_cnt;
    assign w_wdata = w_serve ? data_in : INIT_VALUE;

    assign data_out = (w_serve && data_read && w_in_range) ? w_rdata : 32'h0;
    assign ready    = w_serve;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_addr_err <= 1'b0;
        end else if (w_serve && w_access && !w_in_range) begin
            r_addr_err <= 1'b1;
        end
    end

    assign addr_err = r_addr_err;

`ifdef DMEM_PARITY_EN
    logic w_par_mismatch;
    logic r_par_err;

    dmem_array #(
        .ADDR_BITS (ADDR_BITS)
    ) u_array (
        .clk            (clk),
        .i_we           (w_we),
        .i_waddr        (w_waddr),
        .i_wdata        (w_wdata),
        .i_raddr        (w_idx),
        .o_rdata        (w_rdata),
        .o_par_mismatch (w_par_mismatch)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_par_err <= 1'b0;
        end else if (w_serve && data_read && w_in_range && w_par_mismatch) begin
            r_par_err <= 1'b1;
        end
    end

    assign par_err = r_par_err;
`else
    dmem_array #(
        .ADDR_BITS (ADDR_BITS)
    ) u_array (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_raddr (w_idx),
        .o_rdata (w_rdata)
    );

    assign par_err = 1'b0;
`endif

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 12, meaning word-index width (DEPTH = 2^ADDR_BITS words of 32 bits).
REQ-002 SHALL have parameter INIT_VALUE, default 32'h0000_0000, meaning word value written by the post-reset clear sweep.
REQ-003 SHALL use one clock; reset is asynchronous and active-low; ports are clk and rst.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous active-low reset.
REQ-006 data_read  input  1  read enable from CPU data port.
REQ-007 data_write  input  4  per-byte write strobe; bit i selects byte i, data_in[8i+7:8i].
REQ-008 data_addr  input  32  byte address; bits [1:0] ignored.
REQ-009 data_in  input  32  write data.
REQ-010 data_out  output  32  read data, combinational.
REQ-011 ready  output  1  high once the clear sweep has completed.
REQ-012 addr_err  output  1  sticky out-of-range access flag.
REQ-013 par_err  output  1  sticky parity mismatch flag.

Function
REQ-014 Word index SHALL be data_addr[ADDR_BITS+1:2]; an access is in range iff data_addr[31:ADDR_BITS+2] == 0.
REQ-015 FSM SHALL have two states, CLEAR and SERVE; reset enters CLEAR with clr_cnt = 0.
REQ-016 In CLEAR, each cycle writes INIT_VALUE to mem[clr_cnt], then increments clr_cnt; after writing DEPTH-1, next state is SERVE; sweep takes exactly DEPTH cycles.
REQ-017 ready SHALL be 0 in CLEAR and 1 in SERVE; it rises on the edge after word DEPTH-1 is written.
REQ-018 In CLEAR, CPU reads and writes SHALL be ignored, with data_out = 0 and no flag updates.
REQ-019 In SERVE, at a rising edge with an in-range address, each byte with data_write[i] = 1 SHALL be written; unstrobed bytes keep their value.
REQ-020 In SERVE, data_out SHALL equal mem[index] when data_read = 1 and address is in range, else 0; zero-latency, same cycle.
REQ-021 On simultaneous read and write to the same word, data_out SHALL show pre-write contents during that cycle and new contents from the next cycle.
REQ-022 In SERVE, an out-of-range access (data_read = 1 or data_write != 0) SHALL suppress the write, drive data_out = 0, and set addr_err on the next edge.
REQ-023 addr_err and par_err SHALL stay set until reset.
REQ-024 data_write = 4'b0000 with data_read = 0 SHALL be a no-op.
REQ-025 Assertion of rst mid-sweep SHALL abort the sweep; the sweep restarts at index 0 after release.

Reset
REQ-026 While rst = 0: state = CLEAR, clr_cnt = 0, ready = 0, addr_err = 0, par_err = 0, data_out = 0.
REQ-027 Memory array SHALL have no asynchronous reset; initial contents come only from the clear sweep.

Configuration
REQ-028 Macro DMEM_PARITY_EN: when defined, SHALL store 4 even-parity bits per word, one per byte, and update the bit of each strobed byte on write. The clear sweep SHALL write parity matching INIT_VALUE.
REQ-029 With DMEM_PARITY_EN defined, an in-range SERVE read whose stored parity mismatches the data SHALL set par_err on the next edge; data_out still returns the stored data.
REQ-030 Without DMEM_PARITY_EN, no parity storage SHALL exist and par_err SHALL be constant 0.

Structure
REQ-031 Package dmem_pkg SHALL hold the state enum (CLEAR, SERVE), WORD_BYTES = 4, and the byte-parity function.
REQ-032 Storage SHALL be the sub-module dmem_array: byte-strobed synchronous write, combinational read, optional parity lane. FSM, range check and flags stay in dmem_responder.

Verification (ADDR_BITS = 12)
REQ-033 Release reset; poll ready -> ready = 0 for 4096 cycles, then 1; a read of addr 0x0000_0FFC returns INIT_VALUE.
REQ-034 Write 0xDEADBEEF at 0x10 with strobe 4'b1111, then write 0x000000AA with strobe 4'b0001, then read 0x10 -> 0xDEADBEAA.
REQ-035 Same-cycle read and write of 0x20 (old 0x11111111, new 0x22222222) -> data_out = 0x11111111 that cycle, 0x22222222 next cycle.
REQ-036 Write 0x1 to 0x0000_4000 -> data_out = 0, addr_err = 1 next cycle and after; a read of 0x0 is unchanged.
REQ-037 Assert rst at sweep cycle 100, release, then count -> ready rises after a full 4096 cycles from release.
REQ-038 With DMEM_PARITY_EN defined, force-flip stored bit 3 of word 0x8, read 0x8 -> par_err = 1 next edge; without the macro, par_err stays 0.
